// File: rtl/reglk_wr_gate.sv
// Lock-enforcing write gate for a bank of protected 32-bit config registers.
// Single-beat bus accesses are granted in IDLE and answered one cycle later from RESP.
module reglk_wr_gate #(
    parameter int NUM_REGS = 32,
    parameter int AW       = 8,
    parameter int CNT_W    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [191:0]             reglk_i,
    input  logic                     lock_init_done_i,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [AW-1:0]            addr_i,
    input  logic [31:0]              wdata_i,
    output logic                     gnt_o,
    output logic                     rvalid_o,
    output logic [31:0]              rdata_o,
    output logic                     err_o,
    input  logic                     viol_clr_i,
    output logic                     viol_sticky_o,
    output logic [CNT_W-1:0]         viol_cnt_o,
    output logic [AW-1:0]            viol_addr_o,
    output logic [NUM_REGS*32-1:0]   regs_o
);

    // Handshake: a request is accepted in the cycle where req_i && gnt_o; its
    // response appears on rvalid_o/err_o/rdata_o exactly one cycle later, and
    // no new request is accepted while that response is being presented.
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [31:0]      regs_q [NUM_REGS];
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    vaddr_q, vaddr_d;

    logic [31:0] addr_ext;
    logic        in_range;
    logic        lock_bit;
    logic        eff_lock;
    logic        grant;
    logic        wr_commit;
    logic        viol_evt;
    logic [31:0] rd_word;

    assign addr_ext = 32'(addr_i);
    assign in_range = (addr_ext < 32'(NUM_REGS));
    assign lock_bit = in_range ? reglk_i[addr_ext[7:0]] : 1'b0;
    // Until the lock memory is programmed every register counts as locked.
    assign eff_lock = lock_bit | ~lock_init_done_i;

    assign grant     = (state_q == IDLE) && req_i;
    assign wr_commit = grant && we_i && in_range && !eff_lock;
    assign viol_evt  = grant && we_i && in_range && eff_lock;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_ext == 32'(i)) begin
                rd_word = regs_q[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = RESP;
                    err_d   = !in_range || (we_i && eff_lock);
                    rdata_d = (!we_i && in_range) ? rd_word : 32'h0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_ext == 32'(i)) begin
                    regs_q[i] <= wdata_i;
                end
            end
        end
    end

    // A violation logged in the same cycle as a clear wins over the clear.
    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        vaddr_d  = vaddr_q;
        if (viol_evt) begin
            sticky_d = 1'b1;
            vaddr_d  = addr_i;
            if (viol_clr_i) begin
                cnt_d = CNT_W'(1);
            end else if (!(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (viol_clr_i) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
            vaddr_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            vaddr_q  <= '0;
        end else begin
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            vaddr_q  <= vaddr_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_o[g*32 +: 32] = regs_q[g];
    end

    assign gnt_o         = grant;
    assign rvalid_o      = (state_q == RESP);
    assign err_o         = err_q;
    assign rdata_o       = rdata_q;
    assign viol_sticky_o = sticky_q;
    assign viol_cnt_o    = cnt_q;
    assign viol_addr_o   = vaddr_q;

endmodule

// File: tb/tb_reglk_wr_gate.sv
// Self-checking bench for reglk_wr_gate: scenario tasks plus a response scoreboard.
module tb_reglk_wr_gate;

    localparam int NR = 32;
    localparam int AW = 8;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [191:0]      reglk = '0;
    logic              lock_init = 1'b0;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [AW-1:0]     addr = '0;
    logic [31:0]       wdata = '0;
    logic              viol_clr = 1'b0;
    logic              gnt_o, rvalid_o, err_o, viol_sticky_o;
    logic [31:0]       rdata_o;
    logic [CW-1:0]     viol_cnt_o;
    logic [AW-1:0]     viol_addr_o;
    logic [NR*32-1:0]  regs_o;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    logic [31:0]   m_regs [NR];
    logic          m_sticky;
    logic [CW-1:0] m_cnt;
    logic [AW-1:0] m_addr;

    reglk_wr_gate #(.NUM_REGS(NR), .AW(AW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .reglk_i(reglk), .lock_init_done_i(lock_init),
        .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .viol_clr_i(viol_clr), .viol_sticky_o(viol_sticky_o), .viol_cnt_o(viol_cnt_o),
        .viol_addr_o(viol_addr_o), .regs_o(regs_o)
    );

    always #5 clk = ~clk;

    // Scoreboard: every observed response must match the oldest expectation.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n && rvalid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid got err=%b rdata=%h, required no response", err_o, rdata_o);
            end else begin
                e = exp_q.pop_front();
                if ({err_o, rdata_o} !== e) begin
                    errors++;
                    $display("FAIL response got err=%b rdata=%h, required err=%b rdata=%h",
                             err_o, rdata_o, e[32], e[31:0]);
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_sticky = 1'b0;
        m_cnt    = '0;
        m_addr   = '0;
    endtask

    task automatic access(input logic w, input int a, input logic [31:0] d, input logic clr);
        logic inr, locked, verr, viol;
        logic [31:0] vrd;
        logic [NR*32-1:0] flat;
        @(negedge clk);
        req = 1'b1; we = w; addr = AW'(a); wdata = d; viol_clr = clr;
        inr    = (a < NR);
        locked = (inr ? reglk[a] : 1'b0) | ~lock_init;
        verr   = !inr || (w && locked);
        vrd    = (!w && inr) ? m_regs[a] : 32'h0;
        exp_q.push_back({verr, vrd});
        viol = inr && w && locked;
        if (inr && w && !locked) m_regs[a] = d;
        if (viol) begin
            m_sticky = 1'b1;
            m_addr   = AW'(a);
            m_cnt    = clr ? CW'(1) : ((m_cnt == '1) ? m_cnt : m_cnt + CW'(1));
        end else if (clr) begin
            m_sticky = 1'b0; m_cnt = '0; m_addr = '0;
        end
        #1;
        checks++;
        if (gnt_o !== 1'b1) begin
            errors++; $display("FAIL gnt_idle got %b, required 1", gnt_o);
        end
        @(posedge clk); #1;
        checks++;
        if (gnt_o !== 1'b0) begin
            errors++; $display("FAIL gnt_resp got %b, required 0", gnt_o);
        end
        req = 1'b0; viol_clr = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL resp_timeout pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if ({viol_sticky_o, viol_cnt_o, viol_addr_o} !== {m_sticky, m_cnt, m_addr}) begin
            errors++;
            $display("FAIL viol_log got sticky=%b cnt=%h addr=%0d, required sticky=%b cnt=%h addr=%0d",
                     viol_sticky_o, viol_cnt_o, viol_addr_o, m_sticky, m_cnt, m_addr);
        end
        for (int i = 0; i < NR; i++) flat[i*32 +: 32] = m_regs[i];
        checks++;
        if (regs_o !== flat) begin
            errors++; $display("FAIL regs a=%0d got %h, required %h", a, regs_o[a%NR*32 +: 32], m_regs[a%NR]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rvalid_o, err_o, rdata_o, gnt_o} !== 35'h0) begin
            errors++; $display("FAIL reset_resp got rv=%b err=%b rd=%h gnt=%b, required 0", rvalid_o, err_o, rdata_o, gnt_o);
        end
        checks++;
        if ({viol_sticky_o, viol_cnt_o, viol_addr_o} !== '0 || regs_o !== '0) begin
            errors++; $display("FAIL reset_state got sticky=%b cnt=%h addr=%h, required 0", viol_sticky_o, viol_cnt_o, viol_addr_o);
        end
        @(negedge clk); rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_fail_secure();
        lock_init = 1'b0; reglk = '0;
        access(1'b1, 3, 32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_unlocked_rw();
        lock_init = 1'b1; reglk = '0;
        access(1'b1, 5, 32'h12345678, 1'b0);
        access(1'b0, 5, 32'h0, 1'b0);
        access(1'b1, 31, 32'hA5A5_0031, 1'b0);
        access(1'b0, 31, 32'h0, 1'b0);
    endtask

    task automatic test_locked_write();
        reglk[5] = 1'b1;
        access(1'b1, 5, 32'hFFFFFFFF, 1'b0);
        access(1'b0, 5, 32'h0, 1'b0);
    endtask

    task automatic test_out_of_range();
        access(1'b0, 40, 32'h0, 1'b0);
        access(1'b1, 40, 32'hCAFEF00D, 1'b0);
        access(1'b1, 32, 32'h0BAD0BAD, 1'b0);
    endtask

    task automatic test_clear();
        while (m_cnt < CW'(7)) access(1'b1, 5, $urandom, 1'b0);
        checks++;
        if (viol_cnt_o !== CW'(7)) begin
            errors++; $display("FAIL pre_clear_cnt got %h, required 7", viol_cnt_o);
        end
        access(1'b1, 5, 32'h1, 1'b1);
        @(negedge clk); viol_clr = 1'b1;
        @(negedge clk); viol_clr = 1'b0;
        m_sticky = 1'b0; m_cnt = '0; m_addr = '0;
        #1;
        checks++;
        if ({viol_sticky_o, viol_cnt_o, viol_addr_o} !== '0) begin
            errors++; $display("FAIL clear got sticky=%b cnt=%h addr=%h, required 0", viol_sticky_o, viol_cnt_o, viol_addr_o);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            reglk[31:0] = $urandom;
            lock_init   = ($urandom_range(0, 3) != 0);
            access(1'(($urandom_range(0, 1))), $urandom_range(0, 40), $urandom,
                   ($urandom_range(0, 7) == 0));
        end
    endtask

    task automatic test_reset_in_resp();
        lock_init = 1'b1; reglk = '0;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 8'd7; wdata = 32'h77777777;
        @(posedge clk); #1;
        req = 1'b0; rst_n = 1'b0;
        checks++;
        if (regs_o[7*32 +: 32] !== 32'h77777777) begin
            errors++; $display("FAIL resp_write got %h, required 77777777", regs_o[7*32 +: 32]);
        end
        @(posedge clk); #1;
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (rvalid_o !== 1'b0 || regs_o !== '0 || viol_cnt_o !== '0) begin
                errors++; $display("FAIL post_reset got rv=%b cnt=%h, required rv=0 cnt=0 regs=0", rvalid_o, viol_cnt_o);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_saturation();
        lock_init = 1'b0;
        for (int k = 0; k < 17; k++) access(1'b1, k % NR, $urandom, 1'b0);
        checks++;
        if (viol_cnt_o !== 4'hF || viol_addr_o !== 8'd16) begin
            errors++; $display("FAIL saturate got cnt=%h addr=%0d, required cnt=f addr=16", viol_cnt_o, viol_addr_o);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fail_secure();
        test_unlocked_rw();
        test_locked_write();
        test_out_of_range();
        test_clear();
        test_random();
        test_reset_in_resp();
        test_saturation();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL leftover pending=%0d, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
